systolic_tile_driver: RTL
=========================

# systolic_tile_driver

Operand source and result sink for one systolic tile. Holds an N×N A buffer (rows) and an N×N B buffer (columns) loaded through a host write port. On `start`, it streams N `a_row` beats and N `b_col` beats into the tile over valid/ready. It collects N `c_row` beats from the tile into a result buffer, which the host reads back. It sits between the host/DMA register interface and the tile's a/b/c stream ports.

## Interface
- `N`, 8, tile dimension; lanes per beat and beats per operand
- `IN_W`, 8, operand element width
- `OUT_W`, 16, result element width
- `TIMEOUT`, 1024, idle-cycle limit for the watchdog (used only with `SYSTOLIC_DRIVER_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `wr_en`  in  1  host write strobe
- `wr_sel`  in  1  0 = A buffer, 1 = B buffer
- `wr_idx`  in  $clog2(N)  row/column index
- `wr_data`  in  N*IN_W  row/column data, lane 0 in LSBs
- `start`  in  1  launch one tile job
- `busy`  out  1  job in progress
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  sticky watchdog error
- `rd_idx`  in  $clog2(N)  result row index
- `rd_data`  out  N*OUT_W  result row, combinational read
- `a_valid`  out  1
- `a_ready`  in  1
- `a_row`  out  N*IN_W
- `b_valid`  out  1
- `b_ready`  in  1
- `b_col`  out  N*IN_W
- `c_valid`  in  1
- `c_ready`  out  1
- `c_row`  in  N*OUT_W

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE → RUN:** on `start`=1. `a_cnt`, `b_cnt` and `c_cnt` are cleared to 0.
- **RUN → DONE:** when all three counters have reached N.
- **DONE → IDLE:** unconditionally after one cycle.
- **A stream:**
  - `a_valid` = (RUN && `a_cnt` < N).
  - `a_row` = Abuf[`a_cnt`].
  - `a_cnt` increments on each `a_valid` && `a_ready` handshake.
- **B stream:** same as the A stream, using `b_cnt` and Bbuf. The A and B streams advance independently; neither waits on the other.
- **C stream:**
  - `c_ready` = (RUN && `c_cnt` < N).
  - On each handshake, `c_row` is written to Res[`c_cnt`] and `c_cnt` increments.
  - C beats may arrive while A/B feeding is still in progress.
- **Host writes:**
  - Performed only when `busy`=0.
  - A write in the same cycle as `start` is performed and is visible to the first beat.
  - Writes while `busy`=1 are dropped.
- **`start` outside IDLE:** ignored.
- **`busy`:** `busy` = (state != IDLE). `done` = (state == DONE).
- **Result readback:** `rd_data` = Res[`rd_idx`] at all times. Res is not cleared by `start`.

## Timing
- **Reset values:**
  - Outputs: `busy`, `done`, `err`, `a_valid`, `b_valid`, `c_ready` = 0.
  - Buffers: Abuf, Bbuf and Res all zero.
  - Counters: all 0.
  - State: IDLE.
- **Launch:** `start` sampled at edge t. `a_valid`, `b_valid` and `c_ready` are high from cycle t+1.
- **Handshake stability:** once `a_valid`/`b_valid` is high, data is held stable until the handshake. Valid never drops without a handshake, except on reset or error abort.
- **Completion:**
  - The final handshake at edge t moves the FSM to DONE.
  - `done`=1 during cycle t+1; `busy` falls at t+2.
  - Minimum job length with all readies held high: N+2 cycles from `start` to `busy` low.
- **Reset mid-job:** returns to IDLE immediately. All buffers are cleared and no `done` is emitted.
- **Simultaneous events:** a final handshake on A and on C in the same cycle are both counted.

## Configuration
- Macro: `SYSTOLIC_DRIVER_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit idle counter runs in RUN. It clears on any A, B or C handshake and increments otherwise.
  - When it reaches `TIMEOUT`:
    - `err` is set (sticky until reset).
    - The FSM goes to DONE, so `done` pulses.
    - `a_valid`, `b_valid` and `c_ready` drop.
  - `start` clears the idle counter but not `err`.
- **Undefined:** `err` is tied to 0 and no counter is built.

## Test plan
- **Load and full throughput:**
  - Stimulus: load Abuf[i] = {N{8'(i+1)}} and Bbuf[i] = {N{8'(2*i)}}, pulse `start`, hold `a_ready`, `b_ready` and `c_valid` at 1, and drive `c_row` = beat index.
  - Response: `a_row` sequence is 0x01…,0x02…; `done` arrives at cycle N+1 after `start`; Res[k] = k.
- **A/B back-pressure:**
  - Stimulus: drive `a_ready` with a random 50% pattern and hold `b_ready` low for 5 cycles.
  - Response: `a_row`/`b_col` stay stable while stalled; exactly N handshakes occur on each stream, in order.
- **Early C:**
  - Stimulus: present all N C beats before any A handshake.
  - Response: all N are captured; `done` occurs only after the A and B streams finish.
- **Ignored inputs while busy:**
  - Stimulus: issue `wr_en` to Abuf[0] = 0xFF.. and a second `start` while `busy`.
  - Response: Abuf is unchanged and the job count is unaffected.
- **Reset mid-run:**
  - Stimulus: assert `rst_n`=0 after 3 A beats.
  - Response: all outputs are at their reset values and `rd_data` = 0.
- **Watchdog (with `SYSTOLIC_DRIVER_TIMEOUT_EN`, `TIMEOUT`=16):**
  - Stimulus: hold `c_valid`=0.
  - Response: after the A and B streams finish, `err`=1 and `done` pulses 16 idle cycles later.

Source files
------------

// File: rtl/systolic_tile_driver.sv
// ---------------------------------------------------------------------------
// systolic_tile_driver
//
// Purpose: operand source and result sink for one N x N systolic tile.
//   The host loads an A buffer (one row per entry) and a B buffer (one
//   column per entry). A start pulse launches a job that streams N a_row
//   beats and N b_col beats into the tile over valid/ready. It also
//   collects N c_row beats into a result buffer that the host reads back
//   combinationally.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   wr_en/wr_sel/      host write port (sel 0 = A, 1 = B); writes are
//   wr_idx/wr_data     accepted only while not busy
//   start              launch one job (ignored unless idle)
//   busy/done/err      job in progress / one-cycle completion pulse /
//                      sticky watchdog error
//   rd_idx/rd_data     combinational result-row readback
//   a_valid/a_ready/a_row   A operand stream to the tile
//   b_valid/b_ready/b_col   B operand stream to the tile
//   c_valid/c_ready/c_row   result stream from the tile
//
// Build option: define SYSTOLIC_DRIVER_TIMEOUT_EN to add an idle-cycle
//   watchdog. It aborts a stalled job after TIMEOUT cycles without any
//   handshake and raises err.
// ---------------------------------------------------------------------------
module systolic_tile_driver #(
    parameter int N       = 8,
    parameter int IN_W    = 8,
    parameter int OUT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [$clog2(N)-1:0]   wr_idx,
    input  logic [N*IN_W-1:0]      wr_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    input  logic [$clog2(N)-1:0]   rd_idx,
    output logic [N*OUT_W-1:0]     rd_data,
    output logic                   a_valid,
    input  logic                   a_ready,
    output logic [N*IN_W-1:0]      a_row,
    output logic                   b_valid,
    input  logic                   b_ready,
    output logic [N*IN_W-1:0]      b_col,
    input  logic                   c_valid,
    output logic                   c_ready,
    input  logic [N*OUT_W-1:0]     c_row
);

    localparam int IW = $clog2(N);
    // One extra bit so a counter can hold the terminal value N.
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(N);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       a_cnt_q, a_cnt_d;
    logic [CW-1:0]       b_cnt_q, b_cnt_d;
    logic [CW-1:0]       c_cnt_q, c_cnt_d;

    logic [N*IN_W-1:0]   abuf_q [N];
    logic [N*IN_W-1:0]   bbuf_q [N];
    logic [N*OUT_W-1:0]  res_q  [N];

    logic                run;
    logic                a_hs, b_hs, c_hs;
    logic                host_wr;

    assign run     = (state_q == ST_RUN);
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);

    // Stream data comes straight from the buffers. The counters only move
    // on a handshake, so the data stays stable while the tile stalls.
    assign a_valid = run && (a_cnt_q < CNT_FULL);
    assign b_valid = run && (b_cnt_q < CNT_FULL);
    assign c_ready = run && (c_cnt_q < CNT_FULL);
    assign a_row   = abuf_q[a_cnt_q[IW-1:0]];
    assign b_col   = bbuf_q[b_cnt_q[IW-1:0]];

    assign a_hs    = a_valid && a_ready;
    assign b_hs    = b_valid && b_ready;
    assign c_hs    = c_valid && c_ready;

    // A write in the start cycle still lands because busy is low then.
    assign host_wr = wr_en && !busy;

    assign rd_data = res_q[rd_idx];

`ifdef SYSTOLIC_DRIVER_TIMEOUT_EN
    logic [15:0] idle_q, idle_d;
    logic        err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        c_cnt_d = c_cnt_q;
`ifdef SYSTOLIC_DRIVER_TIMEOUT_EN
        idle_d  = idle_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_cnt_d = '0;
                    b_cnt_d = '0;
                    c_cnt_d = '0;
`ifdef SYSTOLIC_DRIVER_TIMEOUT_EN
                    idle_d  = '0;
`endif
                end
            end
            ST_RUN: begin
                if (a_hs) a_cnt_d = a_cnt_q + CW'(1);
                if (b_hs) b_cnt_d = b_cnt_q + CW'(1);
                if (c_hs) c_cnt_d = c_cnt_q + CW'(1);
                // Look at the post-handshake counts so the final beat on any
                // stream (or several at once) completes the job on that edge.
                if (a_cnt_d == CNT_FULL && b_cnt_d == CNT_FULL &&
                    c_cnt_d == CNT_FULL) begin
                    state_d = ST_DONE;
                end
`ifdef SYSTOLIC_DRIVER_TIMEOUT_EN
                // Without a handshake no counter moved, so the job cannot be
                // finishing in the same cycle as a watchdog expiry.
                if (a_hs || b_hs || c_hs) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + 16'd1;
                    if (idle_d == 16'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- control registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_cnt_q <= '0;
            b_cnt_q <= '0;
            c_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
            c_cnt_q <= c_cnt_d;
        end
    end

`ifdef SYSTOLIC_DRIVER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
            err_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            err_q  <= err_d;
        end
    end
`endif

    // ---------------- operand and result buffers ----------------
    // The buffers must read back as zero after reset, so they are plain
    // resettable registers rather than RAM.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    abuf_q[gi] <= '0;
                    bbuf_q[gi] <= '0;
                end else if (host_wr && wr_idx == IW'(gi)) begin
                    if (wr_sel) bbuf_q[gi] <= wr_data;
                    else        abuf_q[gi] <= wr_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_q[gi] <= '0;
                end else if (c_hs && c_cnt_q[IW-1:0] == IW'(gi)) begin
                    res_q[gi] <= c_row;
                end
            end
        end
    endgenerate

endmodule
